egress_grant_arbiter: RTL
=========================

Name: egress_grant_arbiter

Overview:
- Egress-side responder to the ingress VOQ picker in the fixed-length crossbar switch. One instance per egress port.
- Collects requests from the 4 ingress ports and issues a one-hot grant using round-robin order. The pointer only advances when the grant is accepted (iSLIP-style).
- After an accept, the egress is held for exactly one fixed-length packet transfer. Then it re-arbitrates.
- The ingress side feeds its own voq_picked vector from this block's grants.

Parameters:
PKT_CYCLES, 16, cycles the crossbar is held per accepted grant (range 2..255)
ACCEPT_TIMEOUT, 2, cycles a grant waits for accept before withdrawal (range 1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  4  req[i]=1: ingress i requests this egress (level, held until granted or withdrawn)
accept  input  4  accept[i]=1: ingress i accepts its grant (single-cycle pulse)
grant  output  4  one-hot grant to an ingress; 0 when none
xfer_active  output  1  crossbar path held for a transfer
xfer_src  output  2  ingress index of current/last grant
xfer_done  output  1  1-cycle pulse on the last transfer cycle
rr_ptr  output  2  current highest-priority ingress index

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, xfer_active=0, xfer_src=0, xfer_done=0, rr_ptr=0, timeout counter=0, beat counter=0.
- States: IDLE, GRANT, XFER.
- Arbitration in IDLE: scan index (rr_ptr+k) mod 4 for k=0..3. Winner = first index with req set. Index arithmetic is 2-bit wrap.
- IDLE -> GRANT:
  - When req!=0 at a clock edge.
  - grant=onehot(winner) and xfer_src=winner from the next cycle, i.e. 1-cycle latency.
  - Timeout counter loads ACCEPT_TIMEOUT.
  - If req==0, stay in IDLE with grant=0.
- GRANT, evaluated each edge in priority order:
  1. accept[xfer_src]=1 -> XFER. grant=0, xfer_active=1, beat counter=PKT_CYCLES-1, rr_ptr=xfer_src+1 (mod 4).
  2. req[xfer_src]=0 (request withdrawn) -> IDLE, grant=0, rr_ptr unchanged.
  3. Timeout counter hits 1 -> IDLE, grant=0, rr_ptr unchanged.
  4. Otherwise decrement the timeout counter and hold the grant.
  - accept bits of non-granted ingresses are ignored in every state.
  - accept in IDLE or XFER is ignored.
- XFER:
  - xfer_active=1 for exactly PKT_CYCLES cycles. The beat counter decrements each cycle.
  - xfer_done=1 in the cycle the counter is 0. On the next edge, go to IDLE with xfer_active=0.
  - Requests are not evaluated during XFER. The first new grant can appear 1 cycle after xfer_active falls.
- Simultaneous events:
  - In GRANT, accept and withdrawal on the same edge: accept wins.
  - In GRANT, accept and timeout expiry on the same edge: accept wins.
- grant is always one-hot or zero. grant and xfer_active are never high together.
- Reset mid-XFER or mid-GRANT: immediate return to reset values. No xfer_done pulse.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- When defined, add outputs:
  - grant_cnt (16 bits): increments on each accepted grant, i.e. each GRANT->XFER transition.
  - drop_cnt (16 bits): increments on each withdrawn or timed-out grant.
  - Both counters saturate at 0xFFFF and reset to 0.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, then req=4'b0110 held with rr_ptr=0 -> grant=4'b0010 one cycle later. accept=4'b0010 pulse -> xfer_active high for 16 cycles, xfer_done on the 16th, rr_ptr=2.
- Round-robin fairness: req=4'b1111 held, each grant accepted immediately -> grants cycle 0,1,2,3,0 and rr_ptr follows 1,2,3,0,1.
- Timeout: req=4'b1000, no accept -> grant=4'b1000 for exactly 2 cycles, then 0. rr_ptr stays 0, and the block re-grants ingress 3 next cycle because req is still high.
- Wrong acceptor: grant=4'b0001, accept=4'b0100 -> ignored, grant withdrawn after timeout. Same-edge accept on ingress 0 plus req[0] drop -> XFER entered.
- Reset asserted in XFER cycle 5 -> all outputs 0 immediately, no xfer_done. After release, req=4'b0001 -> grant=4'b0001.
- With ARB_GRANT_STATS_EN: 3 accepted grants and 2 timeouts -> grant_cnt=3, drop_cnt=2.

Source files
------------

// File: rtl/egress_grant_arbiter.sv
// egress_grant_arbiter: per-egress round-robin grant/accept arbiter.
// Optional grant/drop counters are enabled by defining ARB_GRANT_STATS_EN.
module egress_grant_arbiter #(
  parameter int PKT_CYCLES     = 16,
  parameter int ACCEPT_TIMEOUT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] accept,
  output logic [3:0] grant,
  output logic       xfer_active,
  output logic [1:0] xfer_src,
  output logic       xfer_done,
  output logic [1:0] rr_ptr
`ifdef ARB_GRANT_STATS_EN
  ,
  output logic [15:0] grant_cnt,
  output logic [15:0] drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] grant_nxt;
  logic       xa_nxt;
  logic [1:0] src_nxt, ptr_nxt;
  logic [3:0] to_cnt, to_nxt;
  logic [7:0] beat, beat_nxt;
  logic [1:0] win, idx;
  logic       found;

  // First requester at or after rr_ptr, 2-bit wrap.
  always_comb begin
    win   = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    xa_nxt    = xfer_active;
    src_nxt   = xfer_src;
    ptr_nxt   = rr_ptr;
    to_nxt    = to_cnt;
    beat_nxt  = beat;
    unique case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nxt = GRANT;
          grant_nxt = 4'b0001 << win;
          src_nxt   = win;
          to_nxt    = 4'(ACCEPT_TIMEOUT);
        end
      end
      GRANT: begin
        if (accept[xfer_src]) begin
          state_nxt = XFER;
          grant_nxt = 4'b0000;
          xa_nxt    = 1'b1;
          beat_nxt  = 8'(PKT_CYCLES - 1);
          ptr_nxt   = xfer_src + 2'd1;
        end else if (!req[xfer_src] || to_cnt == 4'd1) begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
        end else begin
          to_nxt = to_cnt - 4'd1;
        end
      end
      XFER: begin
        if (beat == 8'd0) begin
          state_nxt = IDLE;
          xa_nxt    = 1'b0;
        end else begin
          beat_nxt = beat - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer_done = xfer_active && (beat == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      xfer_active <= 1'b0;
      xfer_src    <= 2'd0;
      rr_ptr      <= 2'd0;
      to_cnt      <= 4'd0;
      beat        <= 8'd0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      xfer_active <= xa_nxt;
      xfer_src    <= src_nxt;
      rr_ptr      <= ptr_nxt;
      to_cnt      <= to_nxt;
      beat        <= beat_nxt;
    end
  end

`ifdef ARB_GRANT_STATS_EN
  logic acc_evt, drop_evt;
  assign acc_evt  = (state == GRANT) && (state_nxt == XFER);
  assign drop_evt = (state == GRANT) && (state_nxt == IDLE);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      if (acc_evt && grant_cnt != 16'hFFFF)
        grant_cnt <= grant_cnt + 16'd1;
      if (drop_evt && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
`endif

endmodule
